// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing the 8-digit seven-segment path between requesters.
// A newly shown value owns the display for at least HOLD_CYCLES before others may take over.
module display_arbiter #(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [28*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 freeze,
  output logic [27:0]          binario,
  output logic [2:0]           owner,
  output logic                 shown_valid,
  output logic                 hold_active,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

  localparam int unsigned       NR        = N_REQ;
  localparam logic [CNT_W-1:0]  RELOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [27:0]       MAX_SHOWN = 28'd99_999_999;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         owner_d;
  logic [27:0]        bin_d;
  logic               ovf_d, shown_d;
  logic [N_REQ-1:0]   ready_d;

  logic [7:0]         cand;
  logic [27:0]        data_arr [8];
  logic [2:0]         rr_base, rr_win;
  logic               rr_found;
  logic               accept;
  logic [2:0]         win_sel;

  // A requester whose ready pulse is still high is not a candidate.
  always_comb begin
    cand = '0;
    cand[N_REQ-1:0] = req_valid & ~req_ready;
  end

  for (genvar g = 0; g < 8; g++) begin : g_unpack
    if (g < N_REQ) begin : g_used
      assign data_arr[g] = req_data[28*g+27 : 28*g];
    end else begin : g_unused
      assign data_arr[g] = '0;
    end
  end

  assign rr_base = (state_q == OPEN) ? owner : last_q;

  always_comb begin
    logic [2:0] idx;
    idx      = '0;
    rr_found = 1'b0;
    rr_win   = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = 3'((32'(rr_base) + k) % NR);
      if (!rr_found && cand[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    win_sel = rr_win;
    case (state_q)
      IDLE, OPEN: begin
        if (!freeze && rr_found) begin
          accept  = 1'b1;
          state_d = HOLD;
          cnt_d   = RELOAD;
        end
      end
      HOLD: begin
        // Owner refresh wins over expiry in the same cycle.
        if (!freeze) begin
          if (cand[owner]) begin
            accept  = 1'b1;
            win_sel = owner;
            cnt_d   = RELOAD;
          end else if (cnt_q == '0) begin
            state_d = OPEN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    bin_d   = binario;
    owner_d = owner;
    ovf_d   = overflow;
    shown_d = shown_valid;
    last_d  = last_q;
    ready_d = '0;
    if (accept) begin
      bin_d   = data_arr[win_sel];
      owner_d = win_sel;
      ovf_d   = data_arr[win_sel] > MAX_SHOWN;
      shown_d = 1'b1;
      last_d  = win_sel;
      for (int unsigned i = 0; i < NR; i++) begin
        ready_d[i] = (win_sel == 3'(i));
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 3'(N_REQ - 1);
      owner       <= '0;
      binario     <= '0;
      overflow    <= 1'b0;
      shown_valid <= 1'b0;
      req_ready   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner       <= owner_d;
      binario     <= bin_d;
      overflow    <= ovf_d;
      shown_valid <= shown_d;
      req_ready   <= ready_d;
    end
  end

  assign hold_active = (state_q == HOLD);

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: requester drivers, a hold-time reference model feeding a
// scoreboard of expected acceptances, and a monitor that checks each ready pulse.
module tb_display_arbiter;

  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int CW   = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [28*N-1:0]   req_data  = '0;
  logic [N-1:0]      req_ready;
  logic              freeze = 1'b0;
  logic [27:0]       binario;
  logic [2:0]        owner;
  logic              shown_valid, hold_active, overflow;

  display_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .freeze(freeze), .binario(binario), .owner(owner),
    .shown_valid(shown_valid), .hold_active(hold_active), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct { int idx; logic [27:0] data; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 nothing shown yet, 1 value protected, 2 open for takeover
  int          m_mode, m_left, m_last, m_owner, m_w;
  bit          m_shown;
  bit [N-1:0]  m_rdy;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_left = 0; m_last = N - 1; m_owner = 0;
      m_shown = 0; m_rdy = '0;
      sb.delete();
    end else begin
      m_w = -1;
      if (!freeze) begin
        if (m_mode == 1) begin
          if (req_valid[m_owner] && !m_rdy[m_owner]) m_w = m_owner;
        end else begin
          for (int j = 1; j <= N; j++) begin
            int c;
            c = ((m_mode == 2 ? m_owner : m_last) + j) % N;
            if (m_w < 0 && req_valid[c] && !m_rdy[c]) m_w = c;
          end
        end
      end
      m_rdy = '0;
      if (m_w >= 0) begin
        exp_t e;
        e.idx  = m_w;
        e.data = req_data[28*m_w +: 28];
        sb.push_back(e);
        m_rdy[m_w] = 1'b1;
        m_owner = m_w; m_last = m_w;
        m_mode = 1; m_left = HOLD; m_shown = 1;
      end else if (m_mode == 1 && !freeze) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 2;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (req_ready != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'(req_ready), 32'd0);
      end else begin
        exp_t e;
        logic [N-1:0] ev;
        e = sb.pop_front();
        ev = '0;
        ev[e.idx] = 1'b1;
        chk("ready_vec", 32'(req_ready), 32'(ev));
        chk("binario", 32'(binario), 32'(e.data));
        chk("owner", 32'(owner), 32'(e.idx));
        chk("overflow", 32'(overflow), 32'(e.data > 28'd99_999_999));
      end
    end else if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("missing_ready", 32'(req_ready), 32'(1) << e.idx);
    end
    chk("hold_active", 32'(hold_active), 32'(m_mode == 1));
    chk("shown_valid", 32'(shown_valid), 32'(m_shown));
  end

  // ---------------- requester drivers ----------------
  bit          pend [N];
  bit          seen [N];
  logic [27:0] dat  [N];
  bit          rand_en = 1'b0;

  function automatic logic [27:0] rnd_data();
    case ($urandom % 4)
      0:       return 28'd0;
      1:       return 28'($urandom % 100_000_000);
      2:       return 28'(100_000_000 + ($urandom % 168_435_456));
      default: return 28'($urandom);
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_data[28*i +: 28] = dat[i];
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        if (req_ready[i]) begin
          seen[i] = 1'b1;
        end else if (seen[i]) begin
          seen[i] = 1'b0;
          if (rand_en && ($urandom % 3 == 0)) dat[i] = rnd_data();
          else pend[i] = 1'b0;
        end
      end else if (rand_en && ($urandom % 4 == 0)) begin
        pend[i] = 1'b1;
        dat[i]  = rnd_data();
      end
    end
    if (rand_en) freeze = ($urandom % 8 == 0);
    drive();
  endtask

  task automatic req(input int i, input logic [27:0] d);
    pend[i] = 1'b1;
    seen[i] = 1'b0;
    dat[i]  = d;
    drive();
  endtask

  task automatic wait_clear(input int mask, input int budget, input string name);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      step();
      n++;
      busy = 1'b0;
      for (int i = 0; i < N; i++) if (mask[i] && pend[i]) busy = 1'b1;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_binario"}, 32'(binario), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
    chk({tag, "_shown"}, 32'(shown_valid), 32'd0);
    chk({tag, "_hold"}, 32'(hold_active), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; seen[i] = 1'b0; dat[i] = '0;
    end
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    #1 check_cleared("reset");
    @(posedge clock);
    #2 reset = 1'b1;

    repeat (10) step();
    chk("idle_binario", 32'(binario), 32'd0);
    chk("idle_shown", 32'(shown_valid), 32'd0);

    // first acceptance from IDLE, then refresh by the owner while another waits
    req(0, 28'd1234);
    wait_clear(1, 20, "ack_req0");
    req(1, 28'd777);
    req(0, 28'd99);
    wait_clear(3, 40, "ack_req1_after_hold");
    chk("owner_after_hold", 32'(owner), 32'd1);

    // simultaneous requests in OPEN with owner 1: req2 then req0
    repeat (8) step();
    req(0, 28'd11);
    req(2, 28'd22);
    wait_clear(5, 40, "ack_req0_req2");
    chk("owner_rr_second", 32'(owner), 32'd0);

    // overflow boundary
    repeat (8) step();
    req(2, 28'd100_000_000);
    wait_clear(4, 20, "ack_big");
    chk("big_binario", 32'(binario), 32'h5F5E100);
    chk("big_overflow", 32'(overflow), 32'd1);
    repeat (8) step();
    req(2, 28'd5);
    wait_clear(4, 20, "ack_small");
    chk("small_overflow", 32'(overflow), 32'd0);
    chk("small_binario", 32'(binario), 32'd5);

    // freeze mid-hold, then resume; then asynchronous reset mid-hold
    repeat (8) step();
    req(0, 28'd4321);
    wait_clear(1, 20, "ack_pre_freeze");
    freeze = 1'b1;
    req(1, 28'd555);
    repeat (5) step();
    chk("frozen_hold", 32'(hold_active), 32'd1);
    chk("frozen_ready", 32'(req_ready), 32'd0);
    freeze = 1'b0;
    wait_clear(2, 40, "ack_after_freeze");
    chk("freeze_owner", 32'(owner), 32'd1);
    @(negedge clock);
    #1 reset = 1'b0;
    #1 check_cleared("async");
    @(posedge clock);
    #2 reset = 1'b1;

    // randomized traffic with occasional freeze
    rand_en = 1'b1;
    repeat (1500) step();
    rand_en = 1'b0;
    freeze = 1'b0;
    drive();
    wait_clear(7, 300, "drain");
    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 8-digit seven-segment display path (28-bit binary value -> BCD -> digit decoders) between N_REQ requesters, e.g. CPU OUT instruction, PC/debug monitor, switch-input echo.
- Registers the value being shown and drives the display's 28-bit binary input.
- Enforces a minimum on-screen hold time so a value stays readable.
- Rotates ownership round-robin once the hold expires.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- HOLD_CYCLES, 50000000, minimum cycles a newly shown value owns the display (>=1).
- CNT_W, 26, width of hold counter; must hold HOLD_CYCLES-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester value-available flag.
- req_data  input  28*N_REQ  packed values; requester i at bits [28*i+27:28*i].
- req_ready  output  N_REQ  one-cycle acceptance pulse per requester.
- freeze  input  1  debug freeze: no acceptances, hold counter paused.
- binario  output  28  registered value to the seven-segment path.
- owner  output  3  index of requester currently shown.
- shown_valid  output  1  high once any value has been accepted.
- hold_active  output  1  high while in HOLD.
- overflow  output  1  shown value > 99_999_999 (not representable in 8 digits).

Behaviour:
- Reset (asynchronous, reset=0) forces:
  - state=IDLE
  - binario=0, owner=0, shown_valid=0, hold_active=0, overflow=0, req_ready=0
  - hold counter=0
  - round-robin last pointer=N_REQ-1, so the first search starts at 0.
- Reset mid-operation aborts any hold; a pending request is re-arbitrated after release.
- Handshake:
  - Requester raises req_valid with stable req_data and holds both until it sees req_ready=1.
  - It must drop req_valid or present new data in the cycle after the ready pulse.
  - Acceptance of requester i at edge k: binario<=req_data[i], owner<=i, req_ready[i]<=1 for exactly one cycle (k..k+1), overflow<=(req_data[i]>99_999_999).
  - A requester whose req_ready is currently 1 is masked from arbitration, so one request is never accepted twice.
- States:
  - IDLE:
    - If any unmasked valid and freeze=0: accept winner of round-robin search starting at (last+1) mod N_REQ.
    - Set shown_valid=1, counter<=HOLD_CYCLES-1, go HOLD.
  - HOLD:
    - Only the current owner may be accepted (refresh); refresh reloads counter to HOLD_CYCLES-1.
    - Other requesters wait with ready=0.
    - If counter==0 and no refresh: go OPEN; otherwise counter decrements each cycle.
    - HOLD_CYCLES=1 gives exactly one HOLD cycle.
  - OPEN:
    - Any unmasked valid, including the owner, is accepted by round-robin from (owner+1) mod N_REQ.
    - Reload counter, go HOLD.
    - With no valid, stay OPEN; the display keeps the last value.
- Owner refresh in HOLD has priority over the counter reaching 0 in the same cycle.
- freeze=1:
  - Suppresses all acceptances.
  - Pauses the counter; state is unchanged.
  - Outputs hold their values.
  - A ready pulse already issued completes normally.
- Simultaneous valids: exactly one accepted per cycle, chosen by round-robin order.
- hold_active is combinational from state (==HOLD). All other outputs are registered.
- A value of 0 is legal and is shown.
- Width rules: data passes through unmodified, no saturation; the overflow flag is informational only.

Test Plan:
- Reset with all req_valid=0 -> binario=0, owner=0, shown_valid=0, req_ready=0; IDLE persists for 10 cycles.
- N_REQ=3, HOLD_CYCLES=4; req0 valid with data 1234 -> next edge: binario=1234, owner=0, req_ready=001 for one cycle, hold_active=1 for 4 cycles, then OPEN.
- In HOLD from req0, req1 valid with data 777 -> req_ready[1] stays 0 until the hold expires. It is then accepted: binario=777, owner=1. Also: req0 refresh to 99 during HOLD -> accepted immediately, counter reloads.
- In OPEN with owner=1, req0 and req2 valid together -> req2 wins (search from 2). Next window: req0 wins. No requester is accepted twice while valid stays high through the ready cycle.
- Data 100_000_000 from req2 -> overflow=1, binario=0x5F5E100. A subsequent value 5 -> overflow=0.
- freeze=1 mid-HOLD with counter=2 -> counter holds and req1 is not accepted. After freeze=0, the hold resumes with 2 cycles left. Then assert reset=0 asynchronously mid-HOLD -> all outputs clear immediately, without waiting for a clock edge.
